// File: rtl/mem_access_stage.sv
// Memory-access stage: one load or store per request over a ready/ack word bus,
// with lane steering, load extension, and misalignment/illegal/timeout reporting.
module mem_access_stage #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           store_data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           load_data
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW:0] TO_VAL = (CW + 1)'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, RESP, FAIL} state_t;

  state_t                  state_reg, state_next;
  logic [CW-1:0]           cnt_reg, cnt_next;
  logic [CW:0]             cnt_inc;
  logic                    we_reg;
  logic [1:0]              size_reg;
  logic                    unsigned_reg;
  logic [1:0]              lo_reg;
  logic [ADDR_WIDTH-1:0]   mem_addr_reg;
  logic [3:0]              mem_be_reg;
  logic [31:0]             mem_wdata_reg;
  logic [31:0]             load_data_reg;

  logic       request, f3_ok, misaligned, illegal, timeout_hit;
  logic [1:0] size_dec;
  logic [3:0] be_dec;
  logic [31:0] wdata_dec;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign size_dec = funct3[1:0];
  assign request  = req_valid && (MemRead || MemWrite);

  // Stores only take B/H/W; loads additionally allow the unsigned B/H forms.
  always_comb begin
    f3_ok = 1'b0;
    if (MemWrite)
      f3_ok = !funct3[2] && (funct3[1:0] != 2'b11);
    else
      f3_ok = (funct3[1:0] != 2'b11) && !(funct3[2] && funct3[1]);
  end

  assign misaligned = ((size_dec == 2'b01) && addr[0]) ||
                      ((size_dec == 2'b10) && (addr[1:0] != 2'b00));
  assign illegal    = (MemRead && MemWrite) || !f3_ok || misaligned;

  always_comb begin
    case (size_dec)
      2'b00:   be_dec = 4'b0001 << addr[1:0];
      2'b01:   be_dec = addr[1] ? 4'b1100 : 4'b0011;
      default: be_dec = 4'b1111;
    endcase
  end

  // Each byte lane picks the store byte that lands there for the access size.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wdata_dec[8*gi +: 8] = (size_dec == 2'b00) ? store_data[7:0] :
                                  (size_dec == 2'b01) ? store_data[8*(gi%2) +: 8] :
                                                        store_data[8*gi +: 8];
  end

  assign ld_byte = mem_rdata[{lo_reg, 3'b000} +: 8];
  assign ld_half = mem_rdata[{lo_reg[1], 4'b0000} +: 16];

  always_comb begin
    case (size_reg)
      2'b00:   ld_ext = unsigned_reg ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = unsigned_reg ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  assign cnt_inc     = {1'b0, cnt_reg} + (CW + 1)'(1);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == TO_VAL);

  always_comb begin
    state_next = state_reg;
    cnt_next   = '0;
    case (state_reg)
      IDLE: begin
        if (request)
          state_next = illegal ? FAIL : REQ;
      end
      REQ: begin
        cnt_next = cnt_inc[CW-1:0];
        if (mem_ack)
          state_next = RESP;
        else if (timeout_hit)
          state_next = FAIL;
      end
      RESP:    state_next = IDLE;
      FAIL:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      we_reg        <= 1'b0;
      size_reg      <= 2'b00;
      unsigned_reg  <= 1'b0;
      lo_reg        <= 2'b00;
      mem_addr_reg  <= '0;
      mem_be_reg    <= 4'b0000;
      mem_wdata_reg <= '0;
      load_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (state_reg == IDLE && request && !illegal) begin
        we_reg        <= MemWrite;
        size_reg      <= size_dec;
        unsigned_reg  <= funct3[2];
        lo_reg        <= addr[1:0];
        mem_addr_reg  <= {addr[ADDR_WIDTH-1:2], 2'b00};
        mem_be_reg    <= be_dec;
        mem_wdata_reg <= wdata_dec;
      end
      if (state_reg == REQ && mem_ack && !we_reg)
        load_data_reg <= ld_ext;
    end
  end

  assign mem_req   = (state_reg == REQ);
  assign mem_we    = we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_be    = mem_be_reg;
  assign mem_wdata = mem_wdata_reg;
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == RESP);
  assign err       = (state_reg == FAIL);
  assign load_data = load_data_reg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage against a byte-arithmetic reference model,
// plus directed cases for extension, stores, errors, timeout and mid-transaction reset.
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, MemRead, MemWrite;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy, done, err;
  logic [31:0] load_data;

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;
  logic [31:0] model_ld = 32'h0;

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .MemRead(MemRead), .MemWrite(MemWrite),
    .funct3(funct3), .addr(addr), .store_data(store_data), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy), .done(done), .err(err),
    .load_data(load_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: sizes as byte counts, lanes as byte positions.
  function automatic bit legal(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a);
    int nb;
    if (rd && wr) return 1'b0;
    if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b0;
    if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    nb = 1 << f3[1:0];
    return (a % nb) == 0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
    int nb;
    int mask;
    nb = 1 << f3[1:0];
    mask = ((1 << nb) - 1) << (a % 4);
    return mask[3:0];
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] sd);
    logic [31:0] w;
    int nb;
    nb = 1 << f3[1:0];
    for (int k = 0; k < 4; k++) w[8*k +: 8] = sd[8*(k % nb) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    longint unsigned v;
    int bits;
    bits = 8 * (1 << f3[1:0]);
    v = w;
    v = v >> (8 * (a % 4));
    v = v % (64'd1 << bits);
    if (!f3[2] && bits < 32 && v >= (64'd1 << (bits - 1)))
      v = v + (64'd1 << 32) - (64'd1 << bits);
    return v[31:0];
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_txn(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input int dly, input bit hold, input logic [31:0] rword);
    bit lg, got_done, got_err;
    int req_cycles, busy_cycles, end_cycle;
    lg = legal(rd, wr, f3, a);
    check("idle_busy", busy, 0);
    req_valid = 1'b1; MemRead = rd; MemWrite = wr; funct3 = f3; addr = a; store_data = sd;
    req_cycles = 0; busy_cycles = 0; end_cycle = 0; got_done = 0; got_err = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (!hold) req_valid = 1'b0;
      if (busy) busy_cycles++;
      if (mem_req) begin
        check("mem_we", mem_we, wr);
        check("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
        check("mem_be", mem_be, exp_be(f3, a));
        if (wr) check("mem_wdata", mem_wdata, exp_wdata(f3, sd));
        if (req_cycles == dly) begin
          mem_ack = 1'b1; mem_rdata = rword;
        end else begin
          mem_ack = 1'b0; mem_rdata = $urandom;
        end
        req_cycles++;
      end else begin
        mem_ack = 1'b0;
      end
      if (done || err) begin
        got_done = done; got_err = err; end_cycle = cyc;
        break;
      end
    end
    req_valid = 1'b0; mem_ack = 1'b0;
    if (!lg) begin
      check("illegal_err", {got_done, got_err}, 2'b01);
      check("illegal_req_cycles", req_cycles, 0);
      check("illegal_end_cycle", end_cycle, 1);
    end else if (dly < TO) begin
      check("ok_done", {got_done, got_err}, 2'b10);
      check("ok_req_cycles", req_cycles, dly + 1);
      check("ok_end_cycle", end_cycle, dly + 2);
      if (rd) model_ld = exp_load(f3, a, rword);
    end else begin
      check("timeout_err", {got_done, got_err}, 2'b01);
      check("timeout_req_cycles", req_cycles, TO);
      check("timeout_end_cycle", end_cycle, TO + 1);
    end
    check("busy_cycles", busy_cycles, end_cycle);
    check("load_data", load_data, model_ld);
    $display("txn %0d rd=%0d wr=%0d f3=%0d addr=%h sd=%h dly=%0d -> %s", n_txn, rd, wr, f3, a, sd, dly,
             got_done ? "done" : (got_err ? "err" : "none"));
    n_txn++;
    @(negedge clk);
    check("post_busy", busy, 0);
    check("post_pulse", {done, err}, 2'b00);
    if (lg && dly >= TO) begin
      mem_ack = 1'b1; mem_rdata = $urandom;
      @(negedge clk);
      mem_ack = 1'b0;
      check("late_ack_ignored", {busy, done, err}, 3'b000);
      check("late_ack_ld", load_data, model_ld);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 0; MemRead = 0; MemWrite = 0; funct3 = 0; addr = 0;
    store_data = 0; mem_ack = 0; mem_rdata = 0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {mem_req, mem_we, busy, done, err}, 5'b0);
    check("rst_be", mem_be, 4'b0000);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_ld", load_data, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases from the plan.
    run_txn(1, 0, 3'b010, 32'h100, 0, 0, 0, 32'hDEADBEEF);
    check("lw_value", load_data, 32'hDEADBEEF);
    run_txn(1, 0, 3'b000, 32'h203, 0, 1, 0, 32'h80FF7F01);
    check("lb_value", load_data, 32'hFFFFFF80);
    run_txn(1, 0, 3'b100, 32'h203, 0, 0, 1, 32'h80FF7F01);
    check("lbu_value", load_data, 32'h00000080);
    run_txn(1, 0, 3'b001, 32'h202, 0, 2, 0, 32'h80FF7F01);
    check("lh_value", load_data, 32'hFFFF80FF);
    run_txn(1, 0, 3'b101, 32'h202, 0, 0, 0, 32'h80FF7F01);
    check("lhu_value", load_data, 32'h000080FF);
    run_txn(0, 1, 3'b000, 32'h41, 32'h12345678, 2, 1, 32'hCAFEF00D);
    check("sb_ld_unchanged", load_data, 32'h000080FF);
    run_txn(1, 0, 3'b010, 32'h102, 0, 0, 0, 32'h0);
    run_txn(1, 1, 3'b010, 32'h100, 0, 0, 0, 32'h0);
    run_txn(0, 1, 3'b101, 32'h100, 0, 0, 0, 32'h0);
    run_txn(1, 0, 3'b010, 32'h300, 0, 10, 1, 32'h11111111);

    // Reset while the bus request is outstanding.
    req_valid = 1; MemRead = 1; MemWrite = 0; funct3 = 3'b010; addr = 32'h500;
    @(negedge clk);
    req_valid = 0;
    check("midrst_req_up", mem_req, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h5555AAAA;
    model_ld = 32'h0;
    check("midrst_ctrl", {mem_req, busy, done, err}, 4'b0);
    check("midrst_ld", load_data, model_ld);
    @(negedge clk);
    mem_ack = 1'b0;
    check("midrst_ack_ignored", {mem_req, busy, done, err}, 4'b0);
    check("midrst_ld2", load_data, model_ld);
    $display("txn %0d reset during REQ", n_txn);
    n_txn++;

    // Randomized mix, biased toward legal accesses.
    for (int t = 0; t < 150; t++) begin
      bit rd, wr;
      logic [2:0] f3;
      logic [31:0] a;
      int sel;
      sel = $urandom_range(0, 19);
      rd = (sel < 10) || (sel == 19);
      wr = (sel >= 10);
      if ($urandom_range(0, 9) < 8) begin
        sel = $urandom_range(0, 4);
        f3 = (sel < 3) ? 3'(sel) : 3'(sel + 1);
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
      run_txn(rd, wr, f3, a, $urandom, $urandom_range(0, 5), 1'($urandom_range(0, 1)), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
